// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed 7-segment driver for NUM_DIGITS hex digits. One digit is
//   scanned per slot of SCAN_CYCLES clocks. The shared segment bus carries that
//   digit's pattern and a one-hot anode select enables it. The first clock of
//   every slot keeps all anodes off to suppress ghosting. New display data is
//   captured into shadow registers and promoted to the active set only at frame
//   end, so a frame never mixes old and new digits.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   hexs        : digit nibbles, hexs[4i+3:4i] is digit i (digit 0 rightmost)
//   points      : decimal point per digit
//   les         : per-digit flash enable
//   flash_en    : global flash enable
//   lzb         : leading-zero blanking enable
//   load        : one-cycle strobe capturing hexs/points/les
//   load_ack    : one-cycle pulse after the loaded data becomes active
//   frame_done  : high on the last internal clock of each frame
//   seg         : {dp,g,f,e,d,c,b,a}
//   an          : one-hot digit select, an[i] drives digit i
module seg_scan_driver #(
  parameter int NUM_DIGITS  = 8,
  parameter int SCAN_CYCLES = 50000,
  parameter int FLASH_BITS  = 25,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] hexs,
  input  logic [NUM_DIGITS-1:0]   points,
  input  logic [NUM_DIGITS-1:0]   les,
  input  logic                    flash_en,
  input  logic                    lzb,
  input  logic                    load,
  output logic                    load_ack,
  output logic                    frame_done,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SCAN_CYCLES - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic             POL      = (ACTIVE_LOW != 0);

  // Hex to active-high gfedcba.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // Scan state
  logic [CNT_W-1:0]      cnt_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic [FLASH_BITS-1:0] flash_p0;

  // Active (displayed) and shadow (pending) data sets
  logic [4*NUM_DIGITS-1:0] hex_act, hex_sh;
  logic [NUM_DIGITS-1:0]   pts_act, pts_sh, les_act, les_sh;
  logic                    pending;

  // Registered outputs
  logic [7:0]            seg_p1;
  logic [NUM_DIGITS-1:0] an_p1;
  logic                  ack_p1, fd_p1;

  logic                  frame_end, pre_end, blank;
  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [7:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign frame_end = (idx_p0 == IDX_LAST) && (cnt_p0 == CNT_LAST);
  assign pre_end   = (idx_p0 == IDX_LAST) && (cnt_p0 == CNT_PRE);
  assign nib       = hex_act[{idx_p0, 2'b00} +: 4];

  // lz_mask[i] is set when digit i and every digit above it are zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero   = all_zero & (hex_act[4*i +: 4] == 4'd0);
      lz_mask[i] = all_zero;
    end
  end

  assign blank = (flash_en & les_act[idx_p0] & flash_p0[FLASH_BITS-1]) |
                 (lzb & lz_mask[idx_p0] & (idx_p0 != '0));

  assign seg_next = blank ? 8'h00 : {pts_act[idx_p0], hex7(nib)};
  // Guard clock at the start of each slot keeps every anode off.
  assign an_next  = (cnt_p0 == '0) ? '0 : (NUM_DIGITS'(1) << idx_p0);

  // ---- stage p0: scan counters, flash timer, shadow/active data ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0   <= '0;
      idx_p0   <= '0;
      flash_p0 <= '0;
      hex_act  <= '0;
      pts_act  <= '0;
      les_act  <= '0;
      hex_sh   <= '0;
      pts_sh   <= '0;
      les_sh   <= '0;
      pending  <= 1'b0;
      ack_p1   <= 1'b0;
    end else begin
      flash_p0 <= flash_p0 + FLASH_BITS'(1);
      if (cnt_p0 == CNT_LAST) begin
        cnt_p0 <= '0;
        idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
      end else begin
        cnt_p0 <= cnt_p0 + CNT_W'(1);
      end

      if (frame_end) begin
        // A load on the frame-end clock bypasses the shadow and wins over it.
        if (load) begin
          hex_act <= hexs;
          pts_act <= points;
          les_act <= les;
          pending <= 1'b0;
          ack_p1  <= 1'b1;
        end else if (pending) begin
          hex_act <= hex_sh;
          pts_act <= pts_sh;
          les_act <= les_sh;
          pending <= 1'b0;
          ack_p1  <= 1'b1;
        end else begin
          ack_p1  <= 1'b0;
        end
      end else begin
        ack_p1 <= 1'b0;
        if (load) begin
          hex_sh  <= hexs;
          pts_sh  <= points;
          les_sh  <= les;
          pending <= 1'b1;
        end
      end
    end
  end

  // ---- stage p1: output registers with pin polarity applied ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_p1 <= {8{POL}};
      an_p1  <= {NUM_DIGITS{POL}};
      fd_p1  <= 1'b0;
    end else begin
      seg_p1 <= seg_next ^ {8{POL}};
      an_p1  <= an_next ^ {NUM_DIGITS{POL}};
      // Looks one clock ahead so the pulse lines up with the frame-end clock.
      fd_p1  <= pre_end;
    end
  end

  assign seg        = seg_p1;
  assign an         = an_p1;
  assign load_ack   = ack_p1;
  assign frame_done = fd_p1;

endmodule

// File: tb/tb_seg_scan_driver.sv
module tb_seg_scan_driver;

  localparam int N     = 4;
  localparam int S     = 4;
  localparam int FB    = 4;
  localparam int FRAME = N * S;

  localparam logic [6:0] SEG7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                       7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] hexs = '0;
  logic [3:0]  points = '0, les = '0;
  logic        flash_en = 1'b0, lzb = 1'b0, load = 1'b0;
  logic        load_ack, frame_done;
  logic [7:0]  seg;
  logic [3:0]  an;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] an;
    logic       fd;
    logic       ack;
  } exp_t;

  exp_t q[$];

  seg_scan_driver #(
    .NUM_DIGITS(N), .SCAN_CYCLES(S), .FLASH_BITS(FB), .ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hexs(hexs), .points(points), .les(les),
    .flash_en(flash_en), .lzb(lzb), .load(load), .load_ack(load_ack),
    .frame_done(frame_done), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset release determines slot, digit and
  // flash phase; loads are tracked as shadow/active data sets.
  int          t;
  logic [15:0] m_hex, s_hex;
  logic [3:0]  m_pts, s_pts, m_les, s_les;
  bit          m_pend;

  always @(posedge clk) begin
    exp_t e;
    int   d, pos;
    bit   fe, fbit, lz, blank;
    logic [3:0] nib;
    if (!rst_n) begin
      t = 0; m_hex = '0; s_hex = '0; m_pts = '0; s_pts = '0;
      m_les = '0; s_les = '0; m_pend = 0;
      e = '{seg: 8'hFF, an: 4'hF, fd: 1'b0, ack: 1'b0};
    end else begin
      pos   = t % FRAME;
      d     = pos / S;
      fe    = (pos == FRAME - 1);
      fbit  = (t % (1 << FB)) >= (1 << (FB - 1));
      nib   = 4'((m_hex >> (4 * d)) & 16'hF);
      lz    = lzb && (d != 0) && ((m_hex >> (4 * d)) == 16'd0);
      blank = (flash_en && m_les[d] && fbit) || lz;
      e.seg = blank ? 8'hFF : ~{m_pts[d], SEG7[nib]};
      e.an  = ((pos % S) == 0) ? 4'hF : ~(4'b0001 << d);
      e.fd  = (pos == FRAME - 2);
      e.ack = fe && (load || m_pend);
      if (fe) begin
        if (load) begin
          m_hex = hexs; m_pts = points; m_les = les;
        end else if (m_pend) begin
          m_hex = s_hex; m_pts = s_pts; m_les = s_les;
        end
        m_pend = 0;
      end else if (load) begin
        s_hex = hexs; s_pts = points; s_les = les; m_pend = 1;
      end
      t = t + 1;
    end
    q.push_back(e);
  end

  // Monitor: one registered output word per clock, compared off the edge.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_checks++;
      if ({seg, an, frame_done, load_ack} !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t got seg=%h an=%h fd=%b ack=%b required seg=%h an=%h fd=%b ack=%b",
                 $time, seg, an, frame_done, load_ack, e.seg, e.an, e.fd, e.ack);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] p, input logic [3:0] l);
    hexs = h; points = p; les = l; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_frame_end();
    int k;
    k = 0;
    while (frame_done !== 1'b1 && k < 3 * FRAME) begin
      @(negedge clk);
      k++;
    end
    check("frame_done_timeout", 32'(frame_done === 1'b1), 32'd1);
  endtask

  initial begin
    int acks;
    repeat (3) @(negedge clk);
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'hFF);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Mid-frame load; shown from the next frame on.
    repeat (5) @(negedge clk);
    do_load(16'h12AF, 4'b0001, 4'b0000);
    repeat (40) @(negedge clk);

    // Leading-zero blanking.
    lzb = 1'b1;
    do_load(16'h0030, 4'b0000, 4'b0000);
    repeat (40) @(negedge clk);
    do_load(16'h0000, 4'b0000, 4'b0000);
    repeat (40) @(negedge clk);
    lzb = 1'b0;

    // Flash on digit 2.
    flash_en = 1'b1;
    do_load(16'h1234, 4'b0000, 4'b0100);
    repeat (64) @(negedge clk);
    flash_en = 1'b0;

    // Two loads in one frame: last one wins, single ack.
    wait_frame_end();
    repeat (2) @(negedge clk);
    do_load(16'h1111, 4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    do_load(16'h2222, 4'b0000, 4'b0000);
    repeat (40) @(negedge clk);

    // Load on the frame-end clock itself.
    wait_frame_end();
    do_load(16'h9C5E, 4'b1010, 4'b0000);
    repeat (20) @(negedge clk);

    // Randomised traffic.
    for (int i = 0; i < 300; i++) begin
      hexs   = 16'($urandom);
      points = 4'($urandom);
      les    = 4'($urandom);
      load   = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
      if ($urandom_range(0, 15) == 0) flash_en = ~flash_en;
      @(negedge clk);
    end
    load = 1'b0; lzb = 1'b0; flash_en = 1'b0;
    repeat (20) @(negedge clk);

    // Reset mid-slot with a load pending.
    wait_frame_end();
    repeat (3) @(negedge clk);
    do_load(16'h5678, 4'b1111, 4'b0000);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_an", 32'(an), 32'hF);
    check("async_reset_seg", 32'(seg), 32'hFF);
    check("async_reset_ack", 32'(load_ack), 32'd0);
    check("async_reset_fd", 32'(frame_done), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (load_ack === 1'b1) acks++;
    end
    check("no_ack_after_reset", 32'(acks), 32'd0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
